// File: rtl/multi_issue_queue_pkg.sv
// issue_pkg: shared decode helpers for the multi-issue instruction queue.
// Holds the RV32 base opcodes the bundle checker understands, the NOP used to
// fill unissued slots, and pure functions that classify an opcode by its
// register use, memory access and control-flow behaviour.
// Opcodes not listed are treated as no-read, no-write, non-memory,
// non-branch.
package issue_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
      default:                                                  writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: reads_rs1 = 1'b1;
      default:                                             reads_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
      default:                   reads_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    is_ctrl = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multi_issue_queue_if.sv
// multi_issue_queue_if: fetch-side and issue-side signals of the queue.
//   fetch_valid  per-slot valid of the fetch beat (contiguous from bit 0)
//   fetch_instr  fetch beat, slot k at [32k+31:32k]
//   fetch_ready  queue accepts a whole beat this cycle
//   stall        downstream stall, holds the head
//   flush        rollback, empties the queue
//   issue_instr  issued bundle, slot 0 oldest, NOP in invalid slots
//   issue_valid  contiguous prefix of valid issue slots
//   count        current occupancy
// master = fetch/decode side driving the queue, slave = the queue itself.
interface multi_issue_queue_if #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [FETCH_WIDTH-1:0]    fetch_valid;
  logic [32*FETCH_WIDTH-1:0] fetch_instr;
  logic                      fetch_ready;
  logic                      stall;
  logic                      flush;
  logic [32*ISSUE_WIDTH-1:0] issue_instr;
  logic [ISSUE_WIDTH-1:0]    issue_valid;
  logic [CNT_W-1:0]          count;

  modport master (
    output fetch_valid, fetch_instr, stall, flush,
    input  fetch_ready, issue_instr, issue_valid, count
  );

  modport slave (
    input  fetch_valid, fetch_instr, stall, flush,
    output fetch_ready, issue_instr, issue_valid, count
  );
endinterface

// File: rtl/multi_issue_queue_bundle_check.sv
// issue_bundle_check: decides which leading head entries may issue together.
//   head_instr_i  the ISSUE_WIDTH oldest queue entries (slot 0 oldest)
//   avail_i       number of entries actually present in the queue
//   issue_valid_o contiguous prefix of slots that form a legal bundle
// A slot is rejected if it is beyond the occupancy, if any earlier slot was
// rejected, if it reads or rewrites a register written earlier in the bundle,
// if it is a second memory op, or if an earlier slot is a branch/jump.
module issue_bundle_check
  import issue_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int CNT_W       = 4
) (
  input  logic [31:0]            head_instr_i [ISSUE_WIDTH],
  input  logic [CNT_W-1:0]       avail_i,
  output logic [ISSUE_WIDTH-1:0] issue_valid_o
);

  logic [31:0] written;   // registers written by accepted slots; bit 0 stays 0
  logic        mem_seen;
  logic        ctrl_seen;
  logic        chain_ok;
  logic        slot_ok;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  always_comb begin
    issue_valid_o = '0;
    written       = '0;
    mem_seen      = 1'b0;
    ctrl_seen     = 1'b0;
    chain_ok      = 1'b1;
    slot_ok       = 1'b0;
    op            = '0;
    rd            = '0;
    rs1           = '0;
    rs2           = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      op  = head_instr_i[k][6:0];
      rd  = head_instr_i[k][11:7];
      rs1 = head_instr_i[k][19:15];
      rs2 = head_instr_i[k][24:20];

      slot_ok = chain_ok && (CNT_W'(k) < avail_i) && !ctrl_seen &&
                !(mem_seen && is_mem(op));
      if (reads_rs1(op) && written[rs1]) slot_ok = 1'b0;
      if (reads_rs2(op) && written[rs2]) slot_ok = 1'b0;
      if (writes_rd(op) && written[rd])  slot_ok = 1'b0;

      issue_valid_o[k] = slot_ok;
      chain_ok         = slot_ok;
      if (slot_ok) begin
        // x0 never carries a dependency, so it is never marked as written
        if (writes_rd(op) && (rd != 5'd0)) written[rd] = 1'b1;
        mem_seen  = mem_seen  | is_mem(op);
        ctrl_seen = ctrl_seen | is_ctrl(op);
      end
    end
  end

  // Function and immediate fields play no part in hazard detection.
  logic unused_fields;
  always_comb begin
    unused_fields = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++)
      unused_fields = unused_fields ^ (^{head_instr_i[k][31:25], head_instr_i[k][14:12]});
  end

endmodule

// File: rtl/multi_issue_queue.sv
// multi_issue_queue: in-order instruction queue with bundle-forming issue.
//   clk    core clock, rising edge
//   reset  asynchronous active-high, empties the queue
//   bus    multi_issue_queue_if.slave: fetch beat in, issued bundle out,
//          stall/flush control, occupancy
// Storage is a circular buffer addressed by head/tail pointers one bit wider
// than the entry index. Pushed entries become visible to the issue logic the
// cycle after the push edge; there is no empty-queue bypass. Issue outputs are
// combinational from the registered head plus flush; fetch_ready and count
// depend on the registered occupancy only (no same-cycle pop credit).
module multi_issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2
) (
  input logic              clk,
  input logic              reset,
  multi_issue_queue_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push_en;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] pop_cnt;

  logic [31:0]            head_instr [ISSUE_WIDTH];
  logic [IDX_W-1:0]       head_idx   [ISSUE_WIDTH];
  logic [IDX_W-1:0]       wr_idx     [FETCH_WIDTH];
  logic [ISSUE_WIDTH-1:0] chk_valid;

  assign bus.count       = count_q;
  assign bus.fetch_ready = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));

  // Entry index is the pointer modulo DEPTH, so a bundle may straddle the wrap.
  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_head
    assign head_idx[k]   = IDX_W'(head_q + PTR_W'(k));
    assign head_instr[k] = mem_q[head_idx[k]];
  end

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_wr
    assign wr_idx[k] = IDX_W'(tail_q + PTR_W'(k));
  end

  issue_bundle_check #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .CNT_W       (CNT_W)
  ) u_check (
    .head_instr_i  (head_instr),
    .avail_i       (count_q),
    .issue_valid_o (chk_valid)
  );

  // Flush squashes the bundle in the same cycle it empties the queue.
  assign bus.issue_valid = bus.flush ? '0 : chk_valid;

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_out
    assign bus.issue_instr[32*k +: 32] = bus.issue_valid[k] ? head_instr[k] : NOP;
  end

  assign push_en = bus.fetch_ready && (|bus.fetch_valid) && !bus.flush;

  // fetch_valid and issue_valid are contiguous prefixes, so their popcounts
  // are the number of entries moved.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < FETCH_WIDTH; k++)
      push_cnt = push_cnt + CNT_W'(bus.fetch_valid[k]);
    pop_cnt = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++)
      pop_cnt = pop_cnt + CNT_W'(bus.issue_valid[k]);
    if (bus.stall) pop_cnt = '0;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_cnt);
      tail_d  = tail_q + (push_en ? PTR_W'(push_cnt) : PTR_W'(0));
      count_d = count_q + (push_en ? push_cnt : CNT_W'(0)) - pop_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage holds no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int k = 0; k < FETCH_WIDTH; k++)
        if (bus.fetch_valid[k]) mem_q[wr_idx[k]] <= bus.fetch_instr[32*k +: 32];
    end
  end

endmodule

// File: tb/tb_multi_issue_queue.sv
module tb_multi_issue_queue;
  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_issue_queue_if #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) bus ();

  multi_issue_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  logic [31:0] pushed_log[$];
  logic [31:0] issued_log[$];
  int          cur_nv;
  logic [31:0] cur_i0, cur_i1;
  bit          cur_st, cur_fl;
  int          exp_n;

  function automatic bit m_wr(logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                          7'b0010111, 7'b1101111, 7'b1100111};
  endfunction
  function automatic bit m_r1(logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1100111};
  endfunction
  function automatic bit m_r2(logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit m_mem(logic [31:0] i);
    return i[6:0] inside {7'b0000011, 7'b0100011};
  endfunction
  function automatic bit m_ctl(logic [31:0] i);
    return i[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
  endfunction

  // Longest legal prefix, checking each candidate pairwise against every
  // older instruction already in the bundle.
  function automatic int model_len();
    int n = 0;
    for (int k = 0; k < IW; k++) begin
      bit ok = 1;
      if (k >= q.size()) break;
      for (int j = 0; j < k; j++) begin
        logic [31:0] a = q[j];
        logic [31:0] b = q[k];
        if (m_ctl(a)) ok = 0;
        if (m_mem(a) && m_mem(b)) ok = 0;
        if (m_wr(a) && a[11:7] != 5'd0) begin
          if (m_wr(b) && b[11:7] == a[11:7]) ok = 0;
          if (m_r1(b) && b[19:15] == a[11:7]) ok = 0;
          if (m_r2(b) && b[24:20] == a[11:7]) ok = 0;
        end
      end
      if (!ok) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    logic [11:0] im = 12'(imm);
    return {im, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] add_r(int rd, int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(int rd, int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(int rs2, int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd4, 7'b0100011};
  endfunction
  function automatic logic [31:0] beq(int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd8, 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
    return {7'd0, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 3'b000,
            5'($urandom_range(0, 5)), ops[$urandom_range(0, 9)]};
  endfunction

  task automatic drive(input int nv, input logic [31:0] i0, input logic [31:0] i1,
                       input bit st, input bit fl);
    @(negedge clk);
    cur_nv = nv; cur_i0 = i0; cur_i1 = i1; cur_st = st; cur_fl = fl;
    bus.fetch_valid = FW'((1 << nv) - 1);
    bus.fetch_instr = {i1, i0};
    bus.stall       = st;
    bus.flush       = fl;
    #1;
  endtask

  task automatic check_model();
    logic [IW-1:0] ev;
    exp_n = cur_fl ? 0 : model_len();
    ev    = IW'((1 << exp_n) - 1);
    check_eq("count", 64'(bus.count), 64'(q.size()));
    check_eq("fetch_ready", 64'(bus.fetch_ready), 64'((DEPTH - q.size()) >= FW));
    check_eq("issue_valid", 64'(bus.issue_valid), 64'(ev));
    for (int k = 0; k < IW; k++)
      check_eq($sformatf("slot%0d", k), 64'(bus.issue_instr[32*k +: 32]),
               64'((k < exp_n) ? q[k] : NOP_I));
  endtask

  task automatic step();
    bit can_push = (DEPTH - q.size()) >= FW;
    if (!cur_st && !cur_fl)
      for (int k = 0; k < IW; k++)
        if (bus.issue_valid[k]) issued_log.push_back(bus.issue_instr[32*k +: 32]);
    if (cur_fl) q.delete();
    else begin
      if (!cur_st) repeat (exp_n) void'(q.pop_front());
      if (can_push) begin
        if (cur_nv >= 1) begin q.push_back(cur_i0); pushed_log.push_back(cur_i0); end
        if (cur_nv >= 2) begin q.push_back(cur_i1); pushed_log.push_back(cur_i1); end
      end
    end
    @(posedge clk);
  endtask

  task automatic cyc(input int nv, input logic [31:0] i0, input logic [31:0] i1,
                     input bit st, input bit fl);
    drive(nv, i0, i1, st, fl);
    check_model();
    step();
  endtask

  task automatic drain();
    for (int c = 0; c < 64 && q.size() > 0; c++) cyc(0, NOP_I, NOP_I, 0, 0);
    check_eq("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.fetch_valid = '0; bus.fetch_instr = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    #2;
    check_eq("rst_count", 64'(bus.count), 64'd0);
    check_eq("rst_ready", 64'(bus.fetch_ready), 64'd1);
    check_eq("rst_valid", 64'(bus.issue_valid), 64'd0);
    check_eq("rst_instr", 64'(bus.issue_instr), {NOP_I, NOP_I});
    @(negedge clk); reset = 1'b0;

    // Fill to capacity under stall, then offer one more beat while full
    for (int b = 0; b < 4; b++) cyc(2, addi(2*b+1, 0, b), addi(2*b+2, 0, b), 1, 0);
    drive(2, addi(9, 0, 0), addi(10, 0, 0), 1, 0);
    check_eq("fill_count", 64'(bus.count), 64'd8);
    check_eq("fill_ready", 64'(bus.fetch_ready), 64'd0);
    check_model();
    step();
    drain();

    // Independent pair issues together
    cyc(2, addi(1, 0, 1), addi(2, 0, 2), 0, 0);
    drive(0, NOP_I, NOP_I, 0, 0);
    check_eq("pair_count", 64'(bus.count), 64'd2);
    check_eq("pair_valid", 64'(bus.issue_valid), 64'b11);
    check_model(); step();
    drive(0, NOP_I, NOP_I, 0, 0);
    check_eq("pair_empty", 64'(bus.count), 64'd0);
    check_model(); step();

    // RAW split
    cyc(2, addi(1, 0, 1), add_r(3, 1, 1), 0, 0);
    drive(0, NOP_I, NOP_I, 0, 0);
    check_eq("raw_valid1", 64'(bus.issue_valid), 64'b01);
    check_eq("raw_slot1", 64'(bus.issue_instr[63:32]), 64'(NOP_I));
    check_model(); step();
    drive(0, NOP_I, NOP_I, 0, 0);
    check_eq("raw_valid2", 64'(bus.issue_valid), 64'b01);
    check_eq("raw_add", 64'(bus.issue_instr[31:0]), 64'(add_r(3, 1, 1)));
    check_model(); step();

    // Two memory ops split
    cyc(2, lw(5, 1), sw(6, 2), 0, 0);
    drive(0, NOP_I, NOP_I, 0, 0);
    check_eq("mem_valid", 64'(bus.issue_valid), 64'b01);
    check_model(); step();
    drive(0, NOP_I, NOP_I, 0, 0);
    check_eq("mem_sw", 64'(bus.issue_instr[31:0]), 64'(sw(6, 2)));
    check_model(); step();

    // Branch ends the bundle
    cyc(2, beq(1, 2), addi(7, 0, 3), 0, 0);
    drive(0, NOP_I, NOP_I, 0, 0);
    check_eq("br_valid", 64'(bus.issue_valid), 64'b01);
    check_eq("br_slot0", 64'(bus.issue_instr[31:0]), 64'(beq(1, 2)));
    check_model(); step();
    drain();

    // Flush with a simultaneous push at count 5
    cyc(2, addi(1, 0, 1), addi(2, 0, 2), 1, 0);
    cyc(2, addi(3, 0, 3), addi(4, 0, 4), 1, 0);
    cyc(1, addi(5, 0, 5), NOP_I, 1, 0);
    drive(2, addi(6, 0, 6), addi(7, 0, 7), 0, 1);
    check_eq("fl_count5", 64'(bus.count), 64'd5);
    check_eq("fl_valid", 64'(bus.issue_valid), 64'd0);
    check_model(); step();
    drive(0, NOP_I, NOP_I, 0, 0);
    check_eq("fl_count0", 64'(bus.count), 64'd0);
    check_model(); step();

    // Asynchronous reset in the middle of operation
    cyc(2, addi(1, 0, 1), addi(2, 0, 2), 1, 0);
    #2;
    bus.fetch_valid = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("arst_count", 64'(bus.count), 64'd0);
    check_eq("arst_valid", 64'(bus.issue_valid), 64'd0);
    check_eq("arst_ready", 64'(bus.fetch_ready), 64'd1);
    q.delete();
    @(negedge clk); reset = 1'b0;

    // Random traffic with stalls, wrapping the pointers many times
    pushed_log.delete(); issued_log.delete();
    for (int c = 0; c < 300; c++)
      cyc($urandom_range(0, 2), rand_instr(), rand_instr(), $urandom_range(0, 99) < 30, 0);
    drain();
    check_eq("stream_len", 64'(issued_log.size()), 64'(pushed_log.size()));
    for (int i = 0; i < pushed_log.size() && i < issued_log.size(); i++)
      check_eq($sformatf("stream%0d", i), 64'(issued_log[i]), 64'(pushed_log[i]));

    // Random traffic including occasional flushes
    for (int c = 0; c < 200; c++)
      cyc($urandom_range(0, 2), rand_instr(), rand_instr(),
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multi_issue_queue.md
# multi_issue_queue

Parametrised in-order instruction queue and bundle-forming issue stage, sitting between instruction memory and the IF/ID latch of the superscalar core. It generalises the fixed two-wide issue path to ISSUE_WIDTH slots. It buffers up to DEPTH fetched instructions and each cycle issues the longest legal in-order prefix of the queue head. Legality rules: no intra-bundle RAW/WAW hazard, at most one memory op per bundle, and a branch/jump ends the bundle. It supports stall and flush (rollback).

## Interface
- DEPTH, 8: queue entries; power of two, ≥ 2·FETCH_WIDTH.
- FETCH_WIDTH, 2: instructions offered per fetch beat.
- ISSUE_WIDTH, 2: maximum instructions issued per cycle, 1..4.

- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high; clears the queue.
- fetch_valid  in  FETCH_WIDTH  per-slot valid; must be contiguous from bit 0.
- fetch_instr  in  32·FETCH_WIDTH  slot k at bits [32k+31:32k].
- fetch_ready  out  1  queue accepts the whole beat this cycle.
- stall  in  1  downstream hazard stall; no pop.
- flush  in  1  branch rollback; empties the queue.
- issue_instr  out  32·ISSUE_WIDTH  issued bundle; slot 0 is the oldest.
- issue_valid  out  ISSUE_WIDTH  per-slot valid; always a contiguous prefix.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer with head/tail pointers of log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
- **Push:** occurs when fetch_ready && |fetch_valid && !flush. All valid slots are written in order at the tail, and the tail advances by popcount(fetch_valid).
- **fetch_ready:** equals (DEPTH − count) ≥ FETCH_WIDTH, computed from the registered count only. There is no same-cycle pop credit.
- **Bundle formation:** combinational over head entries 0..ISSUE_WIDTH−1. Slot k is valid iff all of the following hold:
  - k < count;
  - slot k−1 is valid;
  - slot k does not read a register that an earlier bundle slot writes (rd ≠ x0);
  - slot k does not write the same rd as an earlier slot (WAW);
  - slot k is not a second load/store in the bundle;
  - no earlier slot is a branch, jal or jalr.
- **Invalid slots:** issue_instr carries NOP 0x00000013.
- **Pop:** when !stall && !flush, head advances by popcount(issue_valid).
- **Stall:** issue_valid and issue_instr still reflect the head, but nothing is popped. Pushes continue.
- **Flush:** has priority over push and pop. At the next edge head = tail = 0 and count = 0. During the flush cycle issue_valid = 0.
- **Simultaneous push and pop:** count_next = count + pushed − popped.
- **Pointer wrap:** pointers wrap modulo 2·DEPTH. Entry index is pointer mod DEPTH, so a bundle may straddle the wrap point.
- **Register-use decode by opcode:**
  - writes rd: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111;
  - reads rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111;
  - reads rs2: 0110011, 0100011, 1100011.
- **Unknown opcodes:** treated as no-read, no-write, non-memory, non-branch.

## Timing
- **Reset values:** fetch_ready = 1, issue_valid = 0, issue_instr = all NOPs, count = 0, head = tail = 0, storage contents don't-care.
- **Latency:** an instruction pushed at edge N can be issued in the cycle after edge N. Fetch-to-issue latency is 1 cycle with no bypass of an empty queue.
- **Output paths:**
  - issue outputs are combinational from registered state plus flush;
  - fetch_ready and count are purely registered.
- **Reset asserted mid-operation:** the queue empties immediately and asynchronously. The outputs above take their reset values without waiting for a clock edge.

## Structure
- **Package `issue_pkg`:** holds
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - the NOP constant;
  - pure functions writes_rd, reads_rs1, reads_rs2, is_mem, is_ctrl.
- **Sub-module `issue_bundle_check`:** combinational; input is ISSUE_WIDTH head instructions plus available count; output is issue_valid. The top holds the storage, pointers and counters.

## Test plan
- **Reset, then fill:** with ISSUE_WIDTH=2 and stall held, push 4 beats of 2 independent ADDIs → count = 8, fetch_ready = 0 after the 4th beat.
- **Independent pair:** push addi x1,x0,1; addi x2,x0,2 → both slots valid, count goes 2→0 in one cycle.
- **RAW split:** push addi x1,x0,1; add x3,x1,x1 → cycle 1 issue_valid = 01, slot 1 = 0x00000013; cycle 2 issues the add.
- **Memory and control limits:**
  - lw followed by sw → issued in separate cycles;
  - beq followed by addi → beq issues alone.
- **Flush with simultaneous push:** with count = 5, assert flush together with a valid fetch beat → next cycle count = 0, and the pushed beat is discarded.
- **Wrap-around:** with DEPTH=8, run 20 beats of mixed traffic under random stall → the issued stream exactly equals the pushed stream in order, and no valid slot ever violates the bundle rules.
